// File: rtl/wb_master_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_master_seq_pkg
// Brief  : Shared types and helpers for the wb_master_seq Wishbone master.
//          State encoding: IDLE=0, REQUEST=1, WAIT_ACK=2, RESPOND=3 (2-bit).
//          Optional timeout feature is controlled by WB_MASTER_SEQ_TIMEOUT_EN
//          (undefined by default: the master waits for ack indefinitely).
// Rev    : 1.0  initial release
// ============================================================================
package wb_master_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESPOND  = 2'd3
  } state_t;

  localparam int CNT_MIN_W = 8;
  localparam int CNT_MAX_W = 32;

  // Width of the timeout counter: just wide enough to hold TIMEOUT_TICKS,
  // clamped to the 8..32 bit range.
  function automatic int timeout_cnt_width(input int ticks);
    int w;
    w = CNT_MIN_W;
    while ((w < CNT_MAX_W) && ((longint'(1) << w) <= longint'(ticks))) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_master_seq_if.sv
`default_nettype none
// ============================================================================
// Module : wb_master_seq_if
// Brief  : Command/response streams plus the multi-slave pipelined Wishbone
//          bus of wb_master_seq.
//   master modport : seen by wb_master_seq
//   slave  modport : seen by the command source / response sink / slaves
//   cmd_*  : valid/ready command (we, sel, adr, dat)
//   rsp_*  : valid/ready response (dat, err)
//   wb_*   : per-slave cyc/stb/ack/stall, shared we/adr/dat_o,
//            concatenated read data (slave k at [k*DATA_WIDTH +: DATA_WIDTH])
// Rev    : 1.0  initial release
// ============================================================================
interface wb_master_seq_if #(
  parameter int SLAVE_NUM  = 3,
  parameter int SEL_WIDTH  = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic                            cmd_we;
  logic [SEL_WIDTH-1:0]            cmd_sel;
  logic [ADDR_WIDTH-1:0]           cmd_adr;
  logic [DATA_WIDTH-1:0]           cmd_dat;
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [DATA_WIDTH-1:0]           rsp_dat;
  logic                            rsp_err;
  logic [SLAVE_NUM-1:0]            wb_cyc_o;
  logic [SLAVE_NUM-1:0]            wb_stb_o;
  logic                            wb_we_o;
  logic [ADDR_WIDTH-1:0]           wb_adr_o;
  logic [DATA_WIDTH-1:0]           wb_dat_o;
  logic [SLAVE_NUM*DATA_WIDTH-1:0] wb_dat_i;
  logic [SLAVE_NUM-1:0]            wb_ack_i;
  logic [SLAVE_NUM-1:0]            wb_stall_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
           wb_dat_i, wb_ack_i, wb_stall_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
           wb_dat_i, wb_ack_i, wb_stall_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_master_seq_mux.sv
`default_nettype none
// ============================================================================
// Module : wb_master_seq_mux
// Brief  : Slave selection for wb_master_seq. Picks the ack/stall/read-data
//          of the selected slave and fans cyc/stb out one-hot to it.
//   sel              in  selected slave index
//   cyc_en, stb_en   in  cycle/strobe request for the selected slave
//   dat_in/ack_in/stall_in  in  per-slave bus returns
//   sel_ack/sel_stall/sel_dat out  returns of the selected slave
//   cyc/stb          out per-slave one-hot cycle/strobe
// An out-of-range sel selects nothing: all returns read 0, no line asserted.
// Rev    : 1.0  initial release
// ============================================================================
module wb_master_seq_mux #(
  parameter int SLAVE_NUM  = 3,
  parameter int SEL_WIDTH  = 2,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic [SEL_WIDTH-1:0]            sel,
  input  wire logic                            cyc_en,
  input  wire logic                            stb_en,
  input  wire logic [SLAVE_NUM*DATA_WIDTH-1:0] dat_in,
  input  wire logic [SLAVE_NUM-1:0]            ack_in,
  input  wire logic [SLAVE_NUM-1:0]            stall_in,
  output logic                                 sel_ack,
  output logic                                 sel_stall,
  output logic [DATA_WIDTH-1:0]                sel_dat,
  output logic [SLAVE_NUM-1:0]                 cyc,
  output logic [SLAVE_NUM-1:0]                 stb
);

  logic [SLAVE_NUM-1:0] w_hit;

  generate
    for (genvar k = 0; k < SLAVE_NUM; k++) begin : g_fanout
      assign w_hit[k] = (sel == SEL_WIDTH'(k));
      assign cyc[k]   = cyc_en & w_hit[k];
      assign stb[k]   = stb_en & w_hit[k];
    end
  endgenerate

  // AND-OR selection keeps every slice index in range.
  always_comb begin
    sel_ack   = 1'b0;
    sel_stall = 1'b0;
    sel_dat   = '0;
    for (int k = 0; k < SLAVE_NUM; k++) begin
      sel_ack   = sel_ack   | (w_hit[k] & ack_in[k]);
      sel_stall = sel_stall | (w_hit[k] & stall_in[k]);
      sel_dat   = sel_dat   | ({DATA_WIDTH{w_hit[k]}} & dat_in[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_master_seq.sv
`default_nettype none
// ============================================================================
// Module : wb_master_seq
// Brief  : Pipelined Wishbone master for SLAVE_NUM slaves. Takes one
//          read/write command at a time, runs one Wishbone cycle to the
//          selected slave and returns data/status on the response stream.
//   wb_clk_i  in  clock
//   wb_rst_i  in  asynchronous active-high reset
//   bus       master modport of wb_master_seq_if (cmd/rsp streams, wb bus)
// Config : define WB_MASTER_SEQ_TIMEOUT_EN to abort a cycle after
//          TIMEOUT_TICKS cycles without ack (err=1). Undefined: no timeout.
// Rev    : 1.0  initial release
// ============================================================================
module wb_master_seq
  import wb_master_seq_pkg::*;
#(
  parameter int SLAVE_NUM     = 3,
  parameter int SEL_WIDTH     = 2,
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT_TICKS = 255
) (
  input wire logic         wb_clk_i,
  input wire logic         wb_rst_i,
  wb_master_seq_if.master  bus
);

  state_t                r_state;
  state_t                w_next;

  logic                  r_we;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [DATA_WIDTH-1:0] r_rsp_dat;
  logic                  r_rsp_err;

  logic                  w_cmd_ready;
  logic                  w_rsp_valid;
  logic                  w_cyc_en;
  logic                  w_stb_en;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_abort;
  logic                  w_sel_bad;
  logic                  w_timeout;

  logic                  w_sel_ack;
  logic                  w_sel_stall;
  logic [DATA_WIDTH-1:0] w_sel_dat;

  assign w_sel_bad = ({1'b0, bus.cmd_sel} >= (SEL_WIDTH+1)'(SLAVE_NUM));

  wb_master_seq_mux #(
    .SLAVE_NUM  (SLAVE_NUM),
    .SEL_WIDTH  (SEL_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .sel       (r_sel),
    .cyc_en    (w_cyc_en),
    .stb_en    (w_stb_en),
    .dat_in    (bus.wb_dat_i),
    .ack_in    (bus.wb_ack_i),
    .stall_in  (bus.wb_stall_i),
    .sel_ack   (w_sel_ack),
    .sel_stall (w_sel_stall),
    .sel_dat   (w_sel_dat),
    .cyc       (bus.wb_cyc_o),
    .stb       (bus.wb_stb_o)
  );

`ifdef WB_MASTER_SEQ_TIMEOUT_EN
  localparam int CNT_W = timeout_cnt_width(TIMEOUT_TICKS);

  logic [CNT_W-1:0] r_cnt;

  // Held at 0 in IDLE, so it starts from 0 on entering REQUEST.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else if ((r_state == ST_REQUEST) || (r_state == ST_WAIT_ACK)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_TICKS - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Ack always takes priority over the timeout on the same edge. In REQUEST
  // an ack only counts on the accepting (non-stalled) edge.
  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_cyc_en    = 1'b0;
    w_stb_en    = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept = 1'b1;
          w_next   = w_sel_bad ? ST_RESPOND : ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        w_cyc_en = 1'b1;
        w_stb_en = 1'b1;
        if (!w_sel_stall && w_sel_ack) begin
          w_capture = 1'b1;
          w_next    = ST_RESPOND;
        end else if (w_timeout) begin
          w_abort = 1'b1;
          w_next  = ST_RESPOND;
        end else if (!w_sel_stall) begin
          w_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        w_cyc_en = 1'b1;
        if (w_sel_ack) begin
          w_capture = 1'b1;
          w_next    = ST_RESPOND;
        end else if (w_timeout) begin
          w_abort = 1'b1;
          w_next  = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Command latch and response registers; all of them only change on
  // accept/capture/abort, so they hold steady throughout RESPOND.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we      <= bus.cmd_we;
        r_sel     <= bus.cmd_sel;
        r_adr     <= bus.cmd_adr;
        r_dat     <= bus.cmd_dat;
        r_rsp_dat <= '0;
        r_rsp_err <= w_sel_bad;
      end
      if (w_capture) begin
        r_rsp_dat <= r_we ? '0 : w_sel_dat;
        r_rsp_err <= 1'b0;
      end
      if (w_abort) begin
        r_rsp_dat <= '0;
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_dat   = r_rsp_dat;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.wb_we_o   = r_we;
  assign bus.wb_adr_o  = r_adr;
  assign bus.wb_dat_o  = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_master_seq
// Brief  : Directed self-checking bench for wb_master_seq with three simple
//          Wishbone slave models (configurable stall length, no-ack mode,
//          forced ack, fixed read data).
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_master_seq;

  localparam int SN  = 3;
  localparam int SW  = 2;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int TOT = 8;

  logic clk;
  logic rst;

  wb_master_seq_if #(.SLAVE_NUM(SN), .SEL_WIDTH(SW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  wb_master_seq #(
    .SLAVE_NUM     (SN),
    .SEL_WIDTH     (SW),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_TICKS (TOT)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave models ----------------
  int          stall_cfg [SN];
  int          stall_cnt [SN];
  logic [SN-1:0] never_ack;
  logic [SN-1:0] force_ack;
  logic [SN-1:0] ack_r;
  logic [SN-1:0] stall_v;
  logic [DW-1:0] rdata [SN];

  always_comb begin
    for (int k = 0; k < SN; k++) begin
      stall_v[k] = bus.wb_stb_o[k] && (stall_cnt[k] < stall_cfg[k]);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SN; k++) begin
        stall_cnt[k] <= 0;
        ack_r[k]     <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SN; k++) begin
        if (bus.wb_stb_o[k] && stall_v[k]) stall_cnt[k] <= stall_cnt[k] + 1;
        else if (!bus.wb_stb_o[k])         stall_cnt[k] <= 0;
        ack_r[k] <= bus.wb_stb_o[k] && !stall_v[k] && !never_ack[k];
      end
    end
  end

  assign bus.wb_stall_i = stall_v;
  assign bus.wb_ack_i   = ack_r | force_ack;
  assign bus.wb_dat_i   = {rdata[2], rdata[1], rdata[0]};

  // ---------------- bus monitor ----------------
  int          stb_cnt [SN];
  int          cyc_cnt [SN];
  logic [DW-1:0] mon_dat;
  logic [AW-1:0] mon_adr;
  logic          mon_we;

  always @(negedge clk) begin
    for (int k = 0; k < SN; k++) begin
      if (bus.wb_stb_o[k]) stb_cnt[k] <= stb_cnt[k] + 1;
      if (bus.wb_cyc_o[k]) cyc_cnt[k] <= cyc_cnt[k] + 1;
    end
    if (|bus.wb_stb_o) begin
      mon_dat <= bus.wb_dat_o;
      mon_adr <= bus.wb_adr_o;
      mon_we  <= bus.wb_we_o;
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts and returns at a falling edge; returns with rsp_valid seen.
  task automatic run_cmd(input logic we, input logic [SW-1:0] sel, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, output int wait_cyc, output int lat,
                         output logic [DW-1:0] rdat, output logic rerr);
    logic acc;
    logic got;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_sel   = sel;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    wait_cyc = 0;
    acc      = 1'b0;
    for (int g = 0; g < 50 && !acc; g++) begin
      if (bus.cmd_ready) acc = 1'b1;
      else begin
        @(negedge clk);
        wait_cyc++;
      end
    end
    check_val("cmd_accepted", {63'd0, acc}, 64'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int g = 0; g < 50 && !got; g++) begin
      @(negedge clk);
      lat++;
      got = bus.rsp_valid;
    end
    check_val("rsp_seen", {63'd0, got}, 64'd1);
    rdat = bus.rsp_dat;
    rerr = bus.rsp_err;
  endtask

  int            wcyc, lat;
  logic [DW-1:0] rd;
  logic          re;
  int            s0, s1, s2;
  logic          seen;

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = '0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.rsp_ready = 1'b1;
    never_ack = '0;
    force_ack = '0;
    for (int k = 0; k < SN; k++) begin
      stall_cfg[k] = 0;
      stb_cnt[k]   = 0;
      cyc_cnt[k]   = 0;
    end
    rdata[0] = 32'h12345678;
    rdata[1] = 32'h0BADF00D;
    rdata[2] = 32'hCAFE0001;

    repeat (3) @(negedge clk);
    // Reset state
    check_val("rst_ready", {63'd0, bus.cmd_ready}, 64'd1);
    check_val("rst_outs", {bus.rsp_valid, bus.rsp_err, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o},
              64'd0);
    check_val("rst_data", {bus.rsp_dat, bus.wb_dat_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write sel=1 adr=3, ack one cycle after stb
    stall_cfg[2] = 2;
    s0 = stb_cnt[0]; s1 = stb_cnt[1]; s2 = stb_cnt[2];
    run_cmd(1'b1, 2'd1, 4'd3, 32'h300, wcyc, lat, rd, re);
    check_val("wr_wait", 64'(wcyc), 64'd0);
    check_val("wr_latency", 64'(lat), 64'd3);
    check_val("wr_err", {63'd0, re}, 64'd0);
    check_val("wr_rdat", {32'd0, rd}, 64'd0);
    check_val("wr_stb_cnt", {16'(stb_cnt[0]-s0), 16'(stb_cnt[1]-s1), 16'(stb_cnt[2]-s2)}, {16'd0, 16'd1, 16'd0});
    check_val("wr_bus", {mon_we, mon_adr, mon_dat}, {1'b1, 4'd3, 32'h300});

    // Back-to-back read sel=2, two stall cycles
    s2 = stb_cnt[2];
    run_cmd(1'b0, 2'd2, 4'd5, 32'h0, wcyc, lat, rd, re);
    check_val("b2b_wait", 64'(wcyc), 64'd1);
    check_val("rd_latency", 64'(lat), 64'd5);
    check_val("rd_dat", {32'd0, rd}, {32'd0, 32'hCAFE0001});
    check_val("rd_err", {63'd0, re}, 64'd0);
    check_val("rd_stb_cnt", 64'(stb_cnt[2]-s2), 64'd3);
    check_val("rd_bus", {mon_we, mon_adr}, {1'b0, 4'd5});
    @(negedge clk);
    stall_cfg[2] = 0;

    // Bad select
    s0 = cyc_cnt[0] + cyc_cnt[1] + cyc_cnt[2];
    run_cmd(1'b0, 2'd3, 4'd1, 32'h0, wcyc, lat, rd, re);
    check_val("bad_latency", 64'(lat), 64'd1);
    check_val("bad_err", {63'd0, re}, 64'd1);
    check_val("bad_rdat", {32'd0, rd}, 64'd0);
    check_val("bad_no_cyc", 64'(cyc_cnt[0] + cyc_cnt[1] + cyc_cnt[2] - s0), 64'd0);
    @(negedge clk);

    // Response held by rsp_ready=0; foreign acks on slave 2 ignored
    bus.rsp_ready = 1'b0;
    force_ack[2]  = 1'b1;
    run_cmd(1'b0, 2'd0, 4'd7, 32'h0, wcyc, lat, rd, re);
    check_val("hold_latency", 64'(lat), 64'd3);
    check_val("hold_rdat", {32'd0, rd}, {32'd0, 32'h12345678});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_stable", {bus.rsp_valid, bus.cmd_ready, bus.rsp_err, bus.rsp_dat},
                {1'b1, 1'b0, 1'b0, 32'h12345678});
    end
    bus.rsp_ready = 1'b1;
    force_ack[2]  = 1'b0;
    @(negedge clk);
    check_val("hold_release", {bus.rsp_valid, bus.cmd_ready}, {1'b0, 1'b1});

`ifdef WB_MASTER_SEQ_TIMEOUT_EN
    // Timeout: slave 1 never acks
    never_ack[1] = 1'b1;
    s1 = cyc_cnt[1];
    run_cmd(1'b0, 2'd1, 4'd2, 32'h0, wcyc, lat, rd, re);
    check_val("to_latency", 64'(lat), 64'd9);
    check_val("to_err", {63'd0, re}, 64'd1);
    check_val("to_rdat", {32'd0, rd}, 64'd0);
    check_val("to_cyc_cnt", 64'(cyc_cnt[1]-s1), 64'd8);
    never_ack[1] = 1'b0;
    @(negedge clk);
    run_cmd(1'b0, 2'd1, 4'd2, 32'h0, wcyc, lat, rd, re);
    check_val("to_followup", {re, rd}, {1'b0, 32'h0BADF00D});
    @(negedge clk);
`endif

    // Reset in WAIT_ACK
    never_ack[0] = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = 2'd0;
    bus.cmd_adr   = 4'd9;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("wack_lines", {bus.wb_cyc_o, bus.wb_stb_o}, {3'b001, 3'b000});
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_async", {bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid, bus.cmd_ready}, {3'b000, 3'b000, 1'b0, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    never_ack[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid | (|bus.wb_cyc_o);
    end
    check_val("rst_no_rsp", {63'd0, seen}, 64'd0);

    // Normal operation after reset
    run_cmd(1'b0, 2'd2, 4'd4, 32'h0, wcyc, lat, rd, re);
    check_val("post_rst_rd", {re, rd}, {1'b0, 32'hCAFE0001});
    check_val("post_rst_lat", 64'(lat), 64'd3);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
